mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 16, memory address width.
REQ-002 The block SHALL have parameter DW, default 16, memory data width.
REQ-003 The block SHALL have parameter MAXSTREAK, default 2, maximum number of consecutive data-port grants while a fetch is pending.
REQ-004 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 i_req  input  1  fetch-port request; held high until i_ack.
REQ-008 i_addr  input  AW  fetch address; stable while i_req is high.
REQ-009 i_ack  output  1  one-cycle fetch completion pulse.
REQ-010 i_rdata  output  DW  fetch read data; valid only while i_ack is high.
REQ-011 d_req  input  1  data-port request; held high until d_ack.
REQ-012 d_we  input  1  data-port write enable (1 = store, 0 = load); stable while d_req is high.
REQ-013 d_addr  input  AW  data address; stable while d_req is high.
REQ-014 d_wdata  input  DW  store data; stable while d_req is high.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 d_rdata  output  DW  load data; valid only while d_ack is high.
REQ-017 mem_addr  output  AW  address to single-port synchronous memory.
REQ-018 mem_we  output  1  memory write strobe.
REQ-019 mem_wdata  output  DW  memory write data.
REQ-020 mem_rdata  input  DW  memory read data, valid one cycle after mem_addr is presented.
REQ-021 busy  output  1  high whenever state is not IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-023 IDLE SHALL do the following: if any request is pending, latch the winner's port, address, we and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-024 ACCESS SHALL last exactly 1 cycle: drive mem_addr and mem_wdata from the latched values, set mem_we = latched we AND winner==D, then go to RESP.
REQ-025 RESP SHALL last 1 cycle: pulse the winner's ack, pass mem_rdata to the winner's rdata, and hold mem_we=0.
REQ-026 On leaving RESP, the block SHALL ignore the acked port and arbitrate the other port; if it is requesting, go directly to ACCESS, else go to IDLE.
REQ-027 Latency SHALL be: request sampled at edge N -> ACCESS in cycle N+1 -> ack in cycle N+2.
REQ-028 Back-to-back throughput SHALL be one access per 2 cycles when the ports alternate, and one per 3 cycles for the same port.
REQ-029 Priority SHALL favour D over I when both requests are pending.
REQ-030 A streak counter SHALL increment on each D grant made while i_req is high, and clear on any I grant.
REQ-031 When streak == MAXSTREAK and i_req is high, the block SHALL grant I regardless of d_req.
REQ-032 The streak counter SHALL saturate at MAXSTREAK.
REQ-033 A D grant made while i_req is low SHALL clear the streak counter.
REQ-034 The fetch port SHALL never cause mem_we=1.
REQ-035 If a request drops before its ack, the access SHALL still complete and the ack SHALL still pulse once.
REQ-036 When not in ACCESS, mem_addr and mem_wdata SHALL hold their last values and mem_we SHALL be 0.
REQ-037 i_ack and d_ack SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per grant.

Reset
REQ-038 Reset assertion SHALL asynchronously force: state=IDLE, i_ack=0, d_ack=0, mem_we=0, busy=0, streak=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0.
REQ-039 Reset asserted during ACCESS SHALL drop mem_we before the next clock edge, so the write is not performed and no ack is issued.
REQ-040 After reset deasserts, the first sampled request SHALL be served normally with no stale grant.

Verification
REQ-041 Fetch-only: i_req=1, i_addr=0x0010, mem holds 0xABCD -> i_ack in the second cycle after sampling, i_rdata=0xABCD, mem_we never 1.
REQ-042 Store then load: d_we=1, d_addr=0x1234, d_wdata=0x5A5A, then d_we=0 at the same address -> mem_we high for exactly 1 cycle, then d_rdata=0x5A5A.
REQ-043 Simultaneous requests with MAXSTREAK=2 and both requests held high -> grant order D,D,I,D,D,I, and no acked port is re-granted straight out of its RESP.
REQ-044 Alternating ports: i_req and d_req both high continuously, with streak forced to I each time -> the RESP->ACCESS direct path is used, with acks 2 cycles apart.
REQ-045 Reset mid-store: reset pulsed during ACCESS of a store of 0xFFFF to 0x0001 -> memory at 0x0001 is unchanged, no d_ack, busy=0 immediately.
REQ-046 Dropped request: d_req=1 for 1 cycle only (load of 0x0002) -> exactly one d_ack, 2 cycles after sampling.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous memory.
// Data port has priority; a streak limit keeps fetch from starving.
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAXSTREAK = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int SW = (MAXSTREAK < 1) ? 1 : $clog2(MAXSTREAK + 1);
    localparam logic [SW-1:0] MAXS = SW'(MAXSTREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          win_d_r, win_d_s;
    logic          grant_s;
    logic [SW-1:0] streak_r, streak_s;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          mem_we_r;
    logic          i_ack_r;
    logic          d_ack_r;
    logic          busy_r;

    // Next-state, winner selection and streak bookkeeping.
    always_comb begin
        state_s  = state_r;
        win_d_s  = win_d_r;
        grant_s  = 1'b0;
        streak_s = streak_r;
        case (state_r)
            IDLE: begin
                if (d_req && !(i_req && (streak_r == MAXS))) begin
                    grant_s = 1'b1;
                    win_d_s = 1'b1;
                end else if (i_req) begin
                    grant_s = 1'b1;
                    win_d_s = 1'b0;
                end else begin
                    grant_s = 1'b0;
                end
            end
            ACCESS: begin
                state_s = RESP;
            end
            RESP: begin
                // The port just acked is not eligible; only the other one may go straight back in.
                if (win_d_r && i_req) begin
                    grant_s = 1'b1;
                    win_d_s = 1'b0;
                end else if (!win_d_r && d_req) begin
                    grant_s = 1'b1;
                    win_d_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (grant_s) begin
            state_s = ACCESS;
            if (win_d_s && i_req) begin
                streak_s = (streak_r == MAXS) ? MAXS : (streak_r + SW'(1));
            end else begin
                streak_s = {SW{1'b0}};
            end
        end else begin
            streak_s = streak_r;
        end
    end

    // State, winner and streak registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            win_d_r  <= 1'b0;
            streak_r <= {SW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            win_d_r  <= win_d_s;
            streak_r <= streak_s;
            busy_r   <= (state_s != IDLE);
        end
    end

    // Memory-side and ack registers; address/data are captured on grant and held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            mem_we_r    <= 1'b0;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
        end else begin
            if (grant_s) begin
                mem_addr_r <= win_d_s ? d_addr : i_addr;
            end
            if (grant_s && win_d_s) begin
                mem_wdata_r <= d_wdata;
            end
            mem_we_r <= grant_s & win_d_s & d_we;
            i_ack_r  <= (state_r == ACCESS) & ~win_d_r;
            d_ack_r  <= (state_r == ACCESS) &  win_d_r;
        end
    end

    // Read data arrives from the memory in the RESP cycle, so it is steered rather than registered.
    assign i_rdata   = i_ack_r ? mem_rdata : {DW{1'b0}};
    assign d_rdata   = d_ack_r ? mem_rdata : {DW{1'b0}};
    assign i_ack     = i_ack_r;
    assign d_ack     = d_ack_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_we, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;
    int iack_cnt = 0, dack_cnt = 0, both_cnt = 0, we_cnt = 0;

    mem_arbiter #(.AW(16), .DW(16), .MAXSTREAK(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (i_ack) iack_cnt <= iack_cnt + 1;
        if (d_ack) dack_cnt <= dack_cnt + 1;
        if (i_ack && d_ack) both_cnt <= both_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_ack(input logic port_d, output int lat, output logic [15:0] data);
        lat  = -1;
        data = 16'h0000;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (port_d ? d_ack : i_ack) begin
                lat  = n;
                data = port_d ? d_rdata : i_rdata;
                break;
            end
        end
    endtask

    task automatic d_xfer(input logic we, input logic [15:0] a, input logic [15:0] w,
                          output int lat, output logic [15:0] r);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
        wait_ack(1'b1, lat, r);
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic i_xfer(input logic [15:0] a, output int lat, output logic [15:0] r);
        @(negedge clk);
        i_req = 1'b1; i_addr = a;
        wait_ack(1'b0, lat, r);
        i_req = 1'b0;
    endtask

    // Both ports request together; the loser withdraws once the winner is visible on mem_addr.
    task automatic grant_both(output logic won_d);
        int lat;
        logic [15:0] r;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        @(negedge clk);
        won_d = (mem_addr == 16'h0020);
        if (won_d) begin
            i_req = 1'b0;
            wait_ack(1'b1, lat, r);
            d_req = 1'b0;
        end else begin
            d_req = 1'b0;
            wait_ack(1'b0, lat, r);
            i_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL reset_acks: got %b%b want 00", i_ack, d_ack); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
        total++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin bad++; $display("FAIL reset_mem: addr %h wdata %h want 0000 0000", mem_addr, mem_wdata); end
        total++; if (i_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata: i %h d %h want 0000 0000", i_rdata, d_rdata); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        int lat, w0;
        logic [15:0] r;
        d_xfer(1'b1, 16'h0010, 16'hABCD, lat, r);
        d_xfer(1'b1, 16'h0001, 16'h1111, lat, r);
        d_xfer(1'b1, 16'h0002, 16'h2222, lat, r);
        d_xfer(1'b1, 16'h0020, 16'h0B0B, lat, r);
        #1 w0 = we_cnt;
        i_xfer(16'h0010, lat, r);
        total++; if (lat !== 2) begin bad++; $display("FAIL fetch_lat: got %0d want 2", lat); end
        total++; if (r !== 16'hABCD) begin bad++; $display("FAIL fetch_data: got %h want abcd", r); end
        #1;
        total++; if (we_cnt - w0 !== 0) begin bad++; $display("FAIL fetch_we: got %0d write cycles want 0", we_cnt - w0); end
    endtask

    task automatic test_store_load();
        int lat, w0;
        logic [15:0] r;
        #1 w0 = we_cnt;
        d_xfer(1'b1, 16'h1234, 16'h5A5A, lat, r);
        total++; if (lat !== 2) begin bad++; $display("FAIL store_lat: got %0d want 2", lat); end
        #1;
        total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL store_we: got %0d write cycles want 1", we_cnt - w0); end
        d_xfer(1'b0, 16'h1234, 16'h0000, lat, r);
        total++; if (r !== 16'h5A5A) begin bad++; $display("FAIL load_data: got %h want 5a5a", r); end
        total++; if (lat !== 2) begin bad++; $display("FAIL load_lat: got %0d want 2", lat); end
    endtask

    task automatic test_alternate();
        int w0, b0;
        logic ei, ed;
        #1 begin w0 = we_cnt; b0 = both_cnt; end
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1234;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            ei = (n % 4 == 0);
            ed = (n % 4 == 2);
            total++; if (i_ack !== ei || d_ack !== ed) begin bad++; $display("FAIL alt_acks_%0d: got i=%b d=%b want i=%b d=%b", n, i_ack, d_ack, ei, ed); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL alt_busy_%0d: got %b want 1", n, busy); end
            if (ed) begin
                total++; if (d_rdata !== 16'h5A5A) begin bad++; $display("FAIL alt_ddata_%0d: got %h want 5a5a", n, d_rdata); end
            end else if (ei) begin
                total++; if (i_rdata !== 16'hABCD) begin bad++; $display("FAIL alt_idata_%0d: got %h want abcd", n, i_rdata); end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL alt_idle: busy %b want 0", busy); end
        #1;
        total++; if (both_cnt - b0 !== 0) begin bad++; $display("FAIL alt_both: got %0d overlapping acks want 0", both_cnt - b0); end
        total++; if (we_cnt - w0 !== 0) begin bad++; $display("FAIL alt_we: got %0d write cycles want 0", we_cnt - w0); end
    endtask

    task automatic test_streak();
        logic won_d;
        logic [5:0] exp_order;
        int lat;
        logic [15:0] r;
        exp_order = 6'b110110;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            grant_both(won_d);
            total++; if (won_d !== exp_order[5-k]) begin bad++; $display("FAIL streak_order_%0d: got D=%b want D=%b", k, won_d, exp_order[5-k]); end
        end
        grant_both(won_d);
        grant_both(won_d);
        total++; if (won_d !== 1'b1) begin bad++; $display("FAIL streak_second_d: got D=%b want D=1", won_d); end
        d_xfer(1'b0, 16'h0020, 16'h0000, lat, r);
        grant_both(won_d);
        total++; if (won_d !== 1'b1) begin bad++; $display("FAIL streak_clear: got D=%b want D=1", won_d); end
    endtask

    task automatic test_reset_mid_store();
        int d0, lat;
        logic [15:0] r;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0001; d_wdata = 16'hFFFF;
        @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_store_we_before: got %b want 1", mem_we); end
        reset = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_store_we_after: got %b want 0", mem_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_store_busy: got %b want 0", busy); end
        d_req = 1'b0; d_we = 1'b0;
        #1 reset = 1'b0;
        d0 = dack_cnt;
        repeat (4) @(negedge clk);
        #1;
        total++; if (dack_cnt - d0 !== 0) begin bad++; $display("FAIL rst_store_ack: got %0d acks want 0", dack_cnt - d0); end
        total++; if (mem[16'h0001] !== 16'h1111) begin bad++; $display("FAIL rst_store_mem: got %h want 1111", mem[16'h0001]); end
        d_xfer(1'b0, 16'h0001, 16'h0000, lat, r);
        total++; if (lat !== 2 || r !== 16'h1111) begin bad++; $display("FAIL rst_first_req: lat %0d data %h want 2 1111", lat, r); end
    endtask

    task automatic test_dropped();
        int d0, first;
        logic [15:0] r;
        #1 d0 = dack_cnt;
        first = -1;
        r = 16'h0000;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
        @(negedge clk);
        d_req = 1'b0;
        for (int n = 2; n <= 8; n++) begin
            @(negedge clk);
            if (d_ack && first < 0) begin
                first = n;
                r = d_rdata;
            end
        end
        #1;
        total++; if (dack_cnt - d0 !== 1) begin bad++; $display("FAIL drop_count: got %0d acks want 1", dack_cnt - d0); end
        total++; if (first !== 2) begin bad++; $display("FAIL drop_lat: got %0d want 2", first); end
        total++; if (r !== 16'h2222) begin bad++; $display("FAIL drop_data: got %h want 2222", r); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_alternate();
        test_streak();
        test_reset_mid_store();
        test_dropped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
